// File: rtl/ctrl_pkg.sv
// Shared state/class encodings and instruction-field layout for the multicycle controller.
// Field positions are fixed within bits [15:0] regardless of INSTR_W.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_LOAD    = 2'd1,
    CLS_STOR    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_class_t;

  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int FN_LSB  = 4;
  localparam int RS_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [FIELD_W-1:0] OPC_RTYPE      = 4'h0;
  localparam logic [FIELD_W-1:0] OPC_ITYPE_LAST = 4'h7;
  localparam logic [FIELD_W-1:0] OPC_LOAD       = 4'h8;
  localparam logic [FIELD_W-1:0] OPC_STOR       = 4'h9;

  // Opcodes 0..7 are ALU work (R-type plus I-types); 8/9 touch memory.
  function automatic instr_class_t classify(input logic [FIELD_W-1:0] opc);
    if (opc <= OPC_ITYPE_LAST) begin
      return CLS_ALU;
    end else if (opc == OPC_LOAD) begin
      return CLS_LOAD;
    end else if (opc == OPC_STOR) begin
      return CLS_STOR;
    end else begin
      return CLS_ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fetch, memory handshake and datapath control bundle.
// slave = controller side, master = instruction/memory/datapath side.
interface multicycle_controller_if #(
  parameter int INSTR_W   = 16,
  parameter int SEL_W     = 4,
  parameter int REG_COUNT = 16,
  parameter int OP_W      = 4
) ();

  logic [INSTR_W-1:0]   instr;
  logic                 instrValid;
  logic                 instrReady;
  logic                 memAck;
  logic                 memReq;
  logic                 memWrite;
  logic                 selectImmediate;
  logic [INSTR_W-1:0]   imm;
  logic [OP_W-1:0]      op;
  logic [SEL_W-1:0]     select1;
  logic [SEL_W-1:0]     select2;
  logic [REG_COUNT-1:0] enableReg;
  logic                 illegalOp;

  modport slave (
    input  instr, instrValid, memAck,
    output instrReady, memReq, memWrite, selectImmediate, imm, op,
           select1, select2, enableReg, illegalOp
  );

  modport master (
    output instr, instrValid, memAck,
    input  instrReady, memReq, memWrite, selectImmediate, imm, op,
           select1, select2, enableReg, illegalOp
  );

endinterface

// File: rtl/instr_decode.sv
// Pure combinational decode of the instruction register into datapath fields.
// LOAD/STOR leave op at 0 with register operand B; the address comes from select2.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int SEL_W   = 4,
  parameter int OP_W    = 4
) (
  input  logic [INSTR_W-1:0] ir_i,
  output logic [OP_W-1:0]    op_o,
  output logic [SEL_W-1:0]   select1_o,
  output logic [SEL_W-1:0]   select2_o,
  output logic               select_imm_o,
  output logic [INSTR_W-1:0] imm_o,
  output instr_class_t       class_o,
  output logic               illegal_o
);

  logic [FIELD_W-1:0] opc;
  logic [IMM_W-1:0]   imm_raw;

  assign opc       = ir_i[OPC_LSB +: FIELD_W];
  assign imm_raw   = ir_i[IMM_LSB +: IMM_W];
  assign select1_o = SEL_W'(ir_i[RD_LSB +: FIELD_W]);
  assign select2_o = SEL_W'(ir_i[RS_LSB +: FIELD_W]);
  assign imm_o     = {{(INSTR_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
  assign class_o   = classify(opc);
  assign illegal_o = (class_o == CLS_ILLEGAL);

  always_comb begin
    op_o         = '0;
    select_imm_o = 1'b0;
    if (class_o == CLS_ALU) begin
      if (opc == OPC_RTYPE) begin
        op_o = OP_W'(ir_i[FN_LSB +: FIELD_W]);
      end else begin
        op_o         = OP_W'(opc);
        select_imm_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and
// drives registered datapath controls; no overlap between instructions.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int SEL_W     = 4,
  parameter int REG_COUNT = 16,
  parameter int OP_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_controller_if.slave bus
);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  logic                 instr_ready_q, instr_ready_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_write_q, mem_write_d;
  logic [REG_COUNT-1:0] enable_reg_q, enable_reg_d;
  logic [OP_W-1:0]      op_q, op_d;
  logic [SEL_W-1:0]     select1_q, select1_d;
  logic [SEL_W-1:0]     select2_q, select2_d;
  logic                 select_imm_q, select_imm_d;
  logic [INSTR_W-1:0]   imm_q, imm_d;
  logic                 illegal_op;

  logic [OP_W-1:0]      dec_op;
  logic [SEL_W-1:0]     dec_select1;
  logic [SEL_W-1:0]     dec_select2;
  logic                 dec_select_imm;
  logic [INSTR_W-1:0]   dec_imm;
  instr_class_t         dec_class;
  logic                 dec_illegal;

  instr_decode #(
    .INSTR_W (INSTR_W),
    .SEL_W   (SEL_W),
    .OP_W    (OP_W)
  ) u_decode (
    .ir_i         (ir_q),
    .op_o         (dec_op),
    .select1_o    (dec_select1),
    .select2_o    (dec_select2),
    .select_imm_o (dec_select_imm),
    .imm_o        (dec_imm),
    .class_o      (dec_class),
    .illegal_o    (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR holds still after FETCH, so the decoder output stays valid through MEM/WB.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.instrValid && instr_ready_q) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = dec_illegal ? FETCH : EXEC;
      EXEC:   state_d = (dec_class == CLS_ALU) ? WB : MEM;
      MEM: begin
        if (bus.memAck) begin
          state_d = (dec_class == CLS_LOAD) ? WB : FETCH;
        end
      end
      WB:      state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from state_d so they line up with the state they belong to.
  always_comb begin
    instr_ready_d = (state_d == FETCH);
    mem_req_d     = (state_d == MEM);
    mem_write_d   = (state_d == MEM) && (dec_class == CLS_STOR);
    enable_reg_d  = '0;
    if (state_d == WB) begin
      enable_reg_d = REG_COUNT'(1) << select1_q;
    end

    op_d         = op_q;
    select1_d    = select1_q;
    select2_d    = select2_q;
    select_imm_d = select_imm_q;
    imm_d        = imm_q;
    if (state_q == DECODE) begin
      op_d         = dec_op;
      select1_d    = dec_select1;
      select2_d    = dec_select2;
      select_imm_d = dec_select_imm;
      imm_d        = dec_imm;
    end

    illegal_op = (state_q == DECODE) && dec_illegal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_ready_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      enable_reg_q  <= '0;
      op_q          <= '0;
      select1_q     <= '0;
      select2_q     <= '0;
      select_imm_q  <= 1'b0;
      imm_q         <= '0;
    end else begin
      instr_ready_q <= instr_ready_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      enable_reg_q  <= enable_reg_d;
      op_q          <= op_d;
      select1_q     <= select1_d;
      select2_q     <= select2_d;
      select_imm_q  <= select_imm_d;
      imm_q         <= imm_d;
    end
  end

  assign bus.instrReady      = instr_ready_q;
  assign bus.memReq          = mem_req_q;
  assign bus.memWrite        = mem_write_q;
  assign bus.enableReg       = enable_reg_q;
  assign bus.op              = op_q;
  assign bus.select1         = select1_q;
  assign bus.select2         = select2_q;
  assign bus.selectImmediate = select_imm_q;
  assign bus.imm             = imm_q;
  assign bus.illegalOp       = illegal_op;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised sequential successor to the combinational instruction decoder.
- Accepts instruction words over a valid/ready handshake and sequences each through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath controls: ALU op, register-file read selects, immediate select, one-hot write enable.
- Sits between instruction memory and the register-file/ALU datapath; adds load/store sequencing with a memory wait handshake.

Parameters:
INSTR_W, 16, instruction width; fields are fixed in bits [15:0], and extra upper bits are ignored.
SEL_W, 4, register select width.
REG_COUNT, 16, number of registers; must equal 2**SEL_W; sets the enableReg width.
OP_W, 4, ALU op width.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr  in  INSTR_W  instruction word
instrValid  in  1  instr is valid
instrReady  out  1  controller can accept instr (registered)
memAck  in  1  memory completed the current request
memReq  out  1  memory request active
memWrite  out  1  1=store, 0=load; meaningful only while memReq=1
selectImmediate  out  1  ALU operand B from immediate
imm  out  INSTR_W  sign-extended instr[7:0]
op  out  OP_W  ALU operation
select1  out  SEL_W  read port 1 select (dest/data reg, instr[11:8])
select2  out  SEL_W  read port 2 select (src/addr reg, instr[3:0])
enableReg  out  REG_COUNT  one-hot register write enable
illegalOp  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; instruction register cleared.
  - All outputs 0.
  - IDLE -> FETCH on the first clock edge after reset_n deasserts.
- Instruction decode, opcode instr[15:12]:
  - 0000, R-type: op=instr[7:4], selectImmediate=0.
  - 0001-0111, I-type: op=opcode, selectImmediate=1.
  - 1000, LOAD: dest=[11:8], addr reg=[3:0].
  - 1001, STOR: data reg=[11:8], addr reg=[3:0].
  - 1010-1111: illegal.
- FETCH:
  - instrReady=1.
  - On instrValid&&instrReady: latch instr into the IR, go to DECODE.
  - Otherwise remain in FETCH.
- DECODE (1 cycle):
  - Register op, select1, select2, selectImmediate and imm from the IR.
  - Illegal opcode: illegalOp=1 for this cycle only, no write, next state FETCH.
- EXEC (1 cycle): ALU/LOAD -> WB for ALU types, -> MEM for LOAD/STOR.
- MEM:
  - memReq=1; memWrite=1 for STOR.
  - Hold in MEM until memAck=1 is sampled.
  - Exit to WB for LOAD, FETCH for STOR.
  - memAck outside MEM is ignored.
- WB (1 cycle): enableReg = 1<<select1, then FETCH.
- Control outputs:
  - enableReg is all-zero in every state except WB.
  - op, select1, select2, selectImmediate and imm hold their decoded values from DECODE until the next DECODE.
- Latency (instr accepted at edge N):
  - ALU: enableReg high during cycle N+3; instrReady high again at N+4 (4 cycles/instr).
  - LOAD with memAck on the first MEM cycle: WB at N+4, FETCH at N+5.
  - Each cycle memAck is late adds one cycle.
- No overlap or pipelining: instrReady=0 in every state except FETCH.
- Reset mid-MEM: memReq drops asynchronously and the transaction is abandoned.
- Reset mid-WB: enableReg drops asynchronously with no write.
- Register 0 is an ordinary writable register.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB;
  - opcode constants: OPC_RTYPE=4'h0, OPC_LOAD=4'h8, OPC_STOR=4'h9;
  - field bit positions.
- One sub-module, instr_decode: pure combinational IR -> {op, selects, selectImmediate, imm, class, illegal}.
- multicycle_controller holds the FSM, IR and output registers.

Test Plan:
- Reset, then hold instrValid=0 for 10 cycles -> state stays FETCH, instrReady=1, enableReg=0, memReq=0.
- instr=16'h0253 (R-type: dest 2, op 5, src 3) -> op=5, select1=2, select2=3, selectImmediate=0; enableReg=16'h0004 exactly at N+3; instrReady high at N+4.
- instr=16'h17F0 (I-type, dest 7, imm 8'hF0) -> selectImmediate=1, op=1, imm=16'hFFF0, enableReg=16'h0080 for one cycle.
- LOAD 16'h8A04 with memAck delayed 3 cycles -> memReq=1, memWrite=0 for 3 cycles, then enableReg=16'h0400; STOR 16'h9A04 -> memWrite=1, no enableReg pulse.
- instr=16'hC000 -> illegalOp pulses exactly 1 cycle, enableReg stays 0, back to FETCH at N+2.
- Assert reset_n=0 mid-MEM of a LOAD -> memReq=0 and all outputs 0 immediately without a clock; after release, IDLE then FETCH, and no write ever occurs.
